// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit beside the ALU.
// Multiply takes one registered cycle; divide/remainder is radix-2 restoring,
// one quotient bit per cycle. freeze_pipe stalls the pipeline until DONE.
// Ports: clk, rst (async, active-low), start_i, op_i (funct3), a_i, b_i,
//   kill_i (flush/trap abort), freeze_pipe, busy_o, done_o (1-cycle pulse),
//   result_o (held until the next result), div_zero_o (with done_o).
// Optional build macro: RISCV_MULDIV_EARLY_OUT_EN -- divide by zero and signed
//   overflow finish straight from the start cycle (IDLE -> DONE).
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            freeze_pipe,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            div_zero_o
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dsr;
    logic [XLEN-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic            neg_a;
    logic            neg_b;
    logic            dz_q;
    logic            ovf_q;

    // Start-cycle decode
    logic            accept;
    logic            div_sgn;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    assign accept  = (state == S_IDLE) & start_i & ~kill_i;
    assign div_sgn = op_i[2] & ~op_i[0];
    assign a_neg   = div_sgn & a_i[XLEN-1];
    assign b_neg   = div_sgn & b_i[XLEN-1];
    assign a_mag   = a_neg ? -a_i : a_i;
    assign b_mag   = b_neg ? -b_i : b_i;
    assign b_zero  = (b_i == '0);
    // Only DIV/REM can overflow: -2^(XLEN-1) / -1
    assign ovf     = div_sgn & (a_i == MIN_NEG) & (b_i == '1);

`ifdef RISCV_MULDIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;

    assign early = op_i[2] & (b_zero | ovf);

    always_comb begin
        early_res = '0;
        if (b_zero) begin
            early_res = op_i[1] ? a_i : '1;
        end else begin
            early_res = op_i[1] ? '0 : a_i;
        end
    end
`endif

    // Multiply: sign-extend to 2*XLEN so one unsigned product
    // covers signed, mixed and unsigned forms.
    logic            mul_sa;
    logic            mul_sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res;

    assign mul_sa  = (op_q == 2'd1 || op_q == 2'd2) & a_q[XLEN-1];
    assign mul_sb  = (op_q == 2'd1) & b_q[XLEN-1];
    assign prod    = {{XLEN{mul_sa}}, a_q} * {{XLEN{mul_sb}}, b_q};
    assign mul_res = (op_q == 2'd0) ? prod[XLEN-1:0]
                                    : prod[2*XLEN-1:XLEN];

    // One restoring step; quotient bits shift into dvd
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] dvd_nx;

    assign shifted = {rem, dvd[XLEN-1]};
    assign ge      = shifted >= {1'b0, dsr};
    // When ge holds the true difference is below dsr, so XLEN bits suffice
    assign diff    = shifted[XLEN-1:0] - dsr;
    assign rem_nx  = ge ? diff : shifted[XLEN-1:0];
    assign dvd_nx  = {dvd[XLEN-2:0], ge};

    logic [XLEN-1:0] div_res;

    always_comb begin
        div_res = '0;
        if (dz_q) begin
            div_res = op_q[1] ? a_q : '1;
        end else if (ovf_q) begin
            div_res = op_q[1] ? '0 : a_q;
        end else if (op_q[1]) begin
            div_res = neg_a ? -rem : rem;
        end else begin
            div_res = (neg_a ^ neg_b) ? -dvd : dvd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        freeze_pipe = 1'b0;
        busy_o      = (state != S_IDLE);
        done_o      = 1'b0;
        div_zero_o  = 1'b0;
        unique case (state)
            S_IDLE: begin
                freeze_pipe = start_i & ~kill_i;
                if (accept) begin
                    state_n = op_i[2] ? S_DIV : S_MUL;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
                    if (early) begin
                        state_n = S_DONE;
                    end
`endif
                end
            end
            S_MUL: begin
                freeze_pipe = 1'b1;
                state_n     = kill_i ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                freeze_pipe = 1'b1;
                if (kill_i) begin
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done_o     = ~kill_i;
                div_zero_o = dz_q & ~kill_i;
                state_n    = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_o <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_i[1:0];
                a_q   <= a_i;
                b_q   <= b_i;
                dvd   <= a_mag;
                dsr   <= b_mag;
                rem   <= '0;
                cnt   <= '0;
                neg_a <= a_neg;
                neg_b <= b_neg;
                dz_q  <= op_i[2] & b_zero;
                ovf_q <= ovf;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
                if (early) begin
                    result_o <= early_res;
                end
`endif
            end
            if (state == S_MUL && !kill_i) begin
                result_o <= mul_res;
            end
            if (state == S_DIV && !kill_i) begin
                if (cnt == CNT_LAST) begin
                    result_o <= div_res;
                end else begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: randomized and directed checks of riscv_muldiv_unit
// against a plain-arithmetic reference model.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        freeze_pipe;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        div_zero_o;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .kill_i      (kill_i),
        .freeze_pipe (freeze_pipe),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .div_zero_o  (div_zero_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == MIN_NEG && b == '1) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: begin
                if (b == 0) return '1;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == '1) return '0;
                return 32'($signed(a) % $signed(b));
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[2]) return 2;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
        if (b == 0 || (!op[0] && a == MIN_NEG && b == '1)) return 1;
`endif
        return XLEN + 2;
    endfunction

    // mode 0: one-cycle start, 1: start held until done,
    // 2: extra start pulse while busy (DIV only)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        int          n;
        int          nfrz;
        int          lat;
        logic [31:0] exp;
        logic        dz;
        exp = model(op, a, b);
        lat = exp_lat(op, a, b);
        dz  = op[2] && (b == 0);
        for (int i = 0; i < 4 && busy_o; i++) cyc();
        op_i    = op;
        a_i     = a;
        b_i     = b;
        kill_i  = 1'b0;
        start_i = 1'b1;
        #1;
        n    = 0;
        nfrz = 0;
        while (n < 60 && !done_o) begin
            if (freeze_pipe) nfrz++;
            cyc();
            n++;
            start_i = (mode == 1) || (mode == 2 && n == 3);
            if (mode == 2 && n == 3) begin
                op_i = 3'd0;
                a_i  = ~a;
            end
            #1;
        end
        check("latency", 64'(n), 64'(lat));
        check("result", {32'b0, result_o}, {32'b0, exp});
        check("div_zero", {63'b0, div_zero_o}, {63'b0, dz});
        check("freeze_cycles", 64'(nfrz), 64'(lat));
        check("freeze_in_done", {63'b0, freeze_pipe}, 64'd0);
        start_i  = 1'b0;
        last_res = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic count_idle_dones(input string tag);
        int nd;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done_o) nd++;
        end
        check(tag, 64'(nd), 64'd0);
        check({tag, "_busy"}, {63'b0, busy_o}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        check("rst_busy", {63'b0, busy_o}, 64'd0);
        check("rst_done", {63'b0, done_o}, 64'd0);
        check("rst_freeze", {63'b0, freeze_pipe}, 64'd0);
        check("rst_dz", {63'b0, div_zero_o}, 64'd0);
        check("rst_result", {32'b0, result_o}, 64'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Reset in the middle of a divide
        run_op(3'd0, 32'd7, 32'd9, 0);
        cyc();
        op_i = 3'd5; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        rst = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy_o}, 64'd0);
        check("midrst_done", {63'b0, done_o}, 64'd0);
        check("midrst_freeze", {63'b0, freeze_pipe}, 64'd0);
        check("midrst_result", {32'b0, result_o}, 64'd0);
        last_res = '0;
        cyc();
        rst = 1'b1;
        cyc();
        run_op(3'd5, 32'd100, 32'd7, 0);

        // Directed multiplies
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 0);

        // Directed divides and corners
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd7, 32'd7, MIN_NEG, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 0);

        // Kill during DIV: no done, result held
        cyc();
        op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        kill_i = 1'b1;
        cyc();
        kill_i = 1'b0;
        #1;
        check("kill_busy", {63'b0, busy_o}, 64'd0);
        count_idle_dones("kill_no_done");
        check("kill_result", {32'b0, result_o}, {32'b0, last_res});

        // Start together with kill is ignored
        kill_i = 1'b1; start_i = 1'b1; op_i = 3'd0;
        #1;
        check("killstart_freeze", {63'b0, freeze_pipe}, 64'd0);
        cyc();
        check("killstart_busy", {63'b0, busy_o}, 64'd0);
        start_i = 1'b0; kill_i = 1'b0;
        cyc();

        // Kill in DONE: done suppressed, result still updated
        op_i = 3'd0; a_i = 32'd5; b_i = 32'd6; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        kill_i = 1'b1;
        #1;
        check("killdone_done", {63'b0, done_o}, 64'd0);
        check("killdone_result", {32'b0, result_o}, 64'd30);
        last_res = 32'd30;
        cyc();
        kill_i = 1'b0;

        // Protocol: held start, pulse while busy, back-to-back
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
        count_idle_dones("held_single_done");
        run_op(3'd5, 32'd12345, 32'd11, 2);
        count_idle_dones("pulse_ignored");
        run_op(3'd7, 32'd77, 32'd10, 0);
        run_op(3'd0, 32'd3, 32'd4, 0);
        run_op(3'd6, 32'd100, 32'hFFFF_FFFD, 0);

        // Randomized operations
        for (int i = 0; i < 250; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
